uart_tx_dev: RTL and testbench



---
 rtl/io_dev_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 27 ++
 rtl/uart_tx_dev.sv | 152 +++++++++++++++
 tb/tb_uart_tx_dev.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_dev_pkg.sv
// Shared constants and types for the memory-mapped I/O devices in the 0xFFFFF0xx page.
package io_dev_pkg;

    localparam int IO_DBITS    = 32;
    localparam int IO_CTRLBITS = 3;
    localparam int IO_CTRL_RDY = 0;
    localparam int IO_CTRL_OVR = 1;
    localparam int IO_CTRL_IE  = 2;

    localparam logic [31:0] IO_TXDATAADDR = 32'hFFFF_F0A0;
    localparam logic [31:0] IO_TXCTRLADDR = 32'hFFFF_F0A4;

    localparam int FRAME_DBITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: one-cycle tick on the last clock of every CLKS_PER_BIT period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Bus-mapped serial transmitter: 8N1 frames on TXD, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_dev
    import io_dev_pkg::*;
#(
    parameter int                DBITS        = IO_DBITS,
    parameter int                CTRLBITS     = IO_CTRLBITS,
    parameter int                CTRL_RDY     = IO_CTRL_RDY,
    parameter int                CTRL_OVR     = IO_CTRL_OVR,
    parameter int                CTRL_IE      = IO_CTRL_IE,
    parameter logic [DBITS-1:0]  TXDATAADDR   = IO_TXDATAADDR,
    parameter logic [DBITS-1:0]  TXCTRLADDR   = IO_TXCTRLADDR,
    parameter int                CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld,
    input  logic             sw,
    input  logic [DBITS-1:0] addrbus,
    inout  wire  [DBITS-1:0] databus,
    output logic             TXD,
    output logic             TXIRQ
);

    tx_state_e state, state_nxt;

    logic                   rdy, ovr, ie;
    logic [FRAME_DBITS-1:0] txdata;
    logic [FRAME_DBITS-1:0] shifter;
    logic [2:0]             bit_cnt;
    logic [CTRLBITS-1:0]    ctrl;
    logic                   tick;
    logic                   load_shifter;
    logic                   wr_data, wr_ctrl, rd_data, rd_ctrl;
`ifdef UART_TX_PARITY_EN
    logic                   par_bit;
`endif

    assign wr_data = sw && (addrbus == TXDATAADDR);
    assign wr_ctrl = sw && (addrbus == TXCTRLADDR);
    assign rd_data = ld && (addrbus == TXDATAADDR);
    assign rd_ctrl = ld && (addrbus == TXCTRLADDR);

    // Holding register drains into the shifter from IDLE or straight out of STOP (no idle gap).
    assign load_shifter = !rdy && ((state == TX_IDLE) || ((state == TX_STOP) && tick));

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(load_shifter),
        .tick   (tick)
    );

    always_comb begin
        ctrl           = '0;
        ctrl[CTRL_RDY] = rdy;
        ctrl[CTRL_OVR] = ovr;
        ctrl[CTRL_IE]  = ie;
    end

    assign databus = rd_data ? DBITS'(txdata) :
                     rd_ctrl ? DBITS'(ctrl)   : {DBITS{1'bz}};

    assign TXIRQ = rdy & ie;

    // Acceptance is judged on the pre-edge RDY, so a store racing a transfer is an overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy    <= 1'b1;
            ovr    <= 1'b0;
            ie     <= 1'b0;
            txdata <= '0;
        end else begin
            if (load_shifter) begin
                rdy <= 1'b1;
            end
            if (wr_data && rdy) begin
                txdata <= databus[FRAME_DBITS-1:0];
                rdy    <= 1'b0;
            end
            if (wr_data && !rdy) begin
                ovr <= 1'b1;
            end else if (wr_ctrl && !databus[CTRL_OVR]) begin
                ovr <= 1'b0;
            end
            if (wr_ctrl) begin
                ie <= databus[CTRL_IE];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:   if (load_shifter) state_nxt = TX_START;
            TX_START:  if (tick) state_nxt = TX_DATA;
            TX_DATA: begin
                if (tick && (bit_cnt == 3'(FRAME_DBITS - 1))) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = TX_PARITY;
`else
                    state_nxt = TX_STOP;
`endif
                end
            end
            TX_PARITY: if (tick) state_nxt = TX_STOP;
            TX_STOP:   if (tick) state_nxt = load_shifter ? TX_START : TX_IDLE;
            default:   state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        TXD = 1'b1;
        case (state)
            TX_START:  TXD = 1'b0;
            TX_DATA:   TXD = shifter[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: TXD = par_bit;
`endif
            default:   TXD = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shifter <= '0;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (load_shifter) begin
            shifter <= txdata;
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^txdata;
`endif
        end else if ((state == TX_DATA) && tick) begin
            shifter <= shifter >> 1;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomised bench for uart_tx_dev: per-cycle TXD/TXIRQ and bus reads against a frame-level model.
module tb_uart_tx_dev;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam logic [31:0] A_DATA  = 32'hFFFF_F0A0;
    localparam logic [31:0] A_CTRL  = 32'hFFFF_F0A4;
    localparam logic [31:0] A_OTHER = 32'hFFFF_F0A8;
    localparam int OP_IDLE = 0;
    localparam int OP_LD   = 1;
    localparam int OP_SW   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld = 1'b0;
    logic        sw = 1'b0;
    logic [31:0] addrbus = '0;
    logic [31:0] drv_data = '0;
    logic        drv_en = 1'b0;
    wire  [31:0] databus;
    wire         txd;
    wire         txirq;

    assign databus = drv_en ? drv_data : 32'bz;

    uart_tx_dev #(.CLKS_PER_BIT(N)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ld     (ld),
        .sw     (sw),
        .addrbus(addrbus),
        .databus(databus),
        .TXD    (txd),
        .TXIRQ  (txirq)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // scoreboard: accepted bytes and the edge at which each frame starts
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         e = 0;
    int         hold_xfer = -1;
    int         line_free = 0;
    logic       ovr_m = 1'b0;
    logic       ie_m = 1'b0;
    logic [7:0] last_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_txd(input int ei);
        foreach (exp_q[i]) begin
            if (ei >= start_q[i] && ei < start_q[i] + FB * N)
                return frame_bit(exp_q[i], (ei - start_q[i]) / N);
        end
        return 1'b1;
    endfunction

    function automatic logic rdy_m();
        return !(hold_xfer >= e + 1);
    endfunction

    function automatic logic [31:0] read_m(input logic [31:0] addr);
        if (addr == A_DATA) return {24'b0, last_m};
        if (addr == A_CTRL) return {29'b0, ie_m, ovr_m, rdy_m()};
        return 32'bz;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data);
        int x;
        if (addr == A_DATA) begin
            if (e <= hold_xfer) begin
                ovr_m = 1'b1;
            end else begin
                x = (e + 1 > line_free) ? e + 1 : line_free;
                hold_xfer = x;
                line_free = x + FB * N;
                last_m = data[7:0];
                exp_q.push_back(data[7:0]);
                start_q.push_back(x);
            end
        end else if (addr == A_CTRL) begin
            if (!data[1]) ovr_m = 1'b0;
            ie_m = data[2];
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        start_q.delete();
        hold_xfer = -1;
        line_free = 0;
        ovr_m = 1'b0;
        ie_m = 1'b0;
        last_m = '0;
    endtask

    // driver: one bus cycle, called from the negedge, checks after the next posedge
    task automatic bus_cycle(input int op, input logic [31:0] addr, input logic [31:0] data);
        ld = (op == OP_LD);
        sw = (op == OP_SW);
        drv_en = (op == OP_SW);
        addrbus = addr;
        drv_data = data;
        @(posedge clk);
        e++;
        if (op == OP_SW) model_store(addr, data);
        while (start_q.size() > 0 && start_q[0] + FB * N <= e) begin
            void'(exp_q.pop_front());
            void'(start_q.pop_front());
        end
        @(negedge clk);
        check("txd", 32'(txd), 32'(exp_txd(e)));
        check("txirq", 32'(txirq), 32'(rdy_m() & ie_m));
        if (op == OP_LD) check("read", databus, read_m(addr));
        ld = 1'b0;
        sw = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(OP_IDLE, '0, '0);
    endtask

    task automatic reset_now();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_txd", 32'(txd), 32'h1);
        check("rst_irq", 32'(txirq), 32'h0);
        ld = 1'b1;
        addrbus = A_CTRL;
        #1;
        check("rst_ctrl", databus, 32'h1);
        ld = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_now();

        // reset state readback
        bus_cycle(OP_LD, A_CTRL, '0);
        bus_cycle(OP_LD, A_DATA, '0);

        // single byte
        bus_cycle(OP_SW, A_DATA, 32'h0000_00A5);
        idle(FB * N + 4);
        bus_cycle(OP_LD, A_DATA, '0);

        // back-to-back, overrun, clear
        bus_cycle(OP_SW, A_DATA, 32'h55);
        idle(10);
        bus_cycle(OP_SW, A_DATA, 32'h0F);
        idle(3);
        bus_cycle(OP_SW, A_DATA, 32'h33);
        bus_cycle(OP_LD, A_CTRL, '0);
        bus_cycle(OP_SW, A_CTRL, 32'h0);
        bus_cycle(OP_LD, A_CTRL, '0);
        idle(2 * FB * N + 4);

        // store on the transfer edge is dropped
        bus_cycle(OP_SW, A_DATA, 32'h81);
        bus_cycle(OP_SW, A_DATA, 32'h42);
        bus_cycle(OP_LD, A_CTRL, '0);
        bus_cycle(OP_SW, A_CTRL, 32'h2);
        bus_cycle(OP_LD, A_CTRL, '0);
        idle(FB * N + 2);

        // interrupt
        bus_cycle(OP_SW, A_CTRL, 32'h4);
        idle(2);
        bus_cycle(OP_SW, A_DATA, 32'h3C);
        idle(FB * N + 4);

        // bus decode
        bus_cycle(OP_LD, A_OTHER, '0);
        bus_cycle(OP_SW, A_OTHER, 32'hFFFF_FFFF);
        bus_cycle(OP_LD, A_CTRL, '0);
        bus_cycle(OP_LD, A_DATA, '0);

        // parity-visible byte
        bus_cycle(OP_SW, A_DATA, 32'h07);
        idle(FB * N + 4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 11);
            case ($urandom_range(0, 3))
                0, 1: a = A_DATA;
                2: a = A_CTRL;
                default: a = A_OTHER;
            endcase
            if (r <= 6) bus_cycle(OP_IDLE, '0, '0);
            else if (r <= 8) bus_cycle(OP_SW, A_DATA, $urandom);
            else if (r == 9) bus_cycle(OP_LD, a, '0);
            else if (r == 10) bus_cycle(OP_SW, A_CTRL, 32'($urandom_range(0, 7)));
            else bus_cycle(OP_SW, a, $urandom);
        end

        // reset mid-frame
        idle(FB * N + 4);
        bus_cycle(OP_SW, A_DATA, 32'hC3);
        bus_cycle(OP_SW, A_CTRL, 32'h4);
        idle(15);
        reset_now();
        bus_cycle(OP_LD, A_CTRL, '0);
        idle(FB * N);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
